// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-side operand selection feeding the ALU.
// Captures decoded fields and control bits from ID, decodes the ALU operation
// ahead of the register, and forwards EX/MEM and MEM/WB results onto the ALU
// operands and the store data path.
module id_ex_stage #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         flush,
    input  logic [W-1:0] id_rs_data,
    input  logic [W-1:0] id_rt_data,
    input  logic [W-1:0] id_imm,
    input  logic [4:0]   id_rs,
    input  logic [4:0]   id_rt,
    input  logic [4:0]   id_rd,
    input  logic [5:0]   id_funct,
    input  logic [1:0]   id_alu_op,
    input  logic         id_alu_src,
    input  logic         id_reg_dst,
    input  logic         id_reg_write,
    input  logic         id_mem_read,
    input  logic         id_mem_write,
    input  logic         id_mem_to_reg,
    input  logic         exmem_reg_write,
    input  logic [4:0]   exmem_rd,
    input  logic [W-1:0] exmem_result,
    input  logic         memwb_reg_write,
    input  logic [4:0]   memwb_rd,
    input  logic [W-1:0] memwb_result,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [3:0]   alu_opsel,
    output logic [W-1:0] ex_store_data,
    output logic [4:0]   ex_write_reg,
    output logic [4:0]   ex_rs,
    output logic [4:0]   ex_rt,
    output logic         ex_reg_write,
    output logic         ex_mem_read,
    output logic         ex_mem_write,
    output logic         ex_mem_to_reg,
    output logic         ex_valid
);

    // ALU operation encodings
    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_OR  = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h6;
    localparam logic [3:0] OP_SLT = 4'h7;
    localparam logic [3:0] OP_BAD = 4'hF;

    // Maps the main-decoder class and funct field onto an ALU operation.
    // Unknown R-type funct codes map to OP_BAD, which the ALU turns into 0.
    function automatic logic [3:0] alu_decode(input logic [1:0] op, input logic [5:0] funct);
        logic [3:0] sel;
        case (op)
            2'b00:   sel = OP_ADD;
            2'b01:   sel = OP_SUB;
            2'b11:   sel = OP_OR;
            2'b10: begin
                case (funct)
                    6'b100000: sel = OP_ADD;
                    6'b100010: sel = OP_SUB;
                    6'b100100: sel = OP_AND;
                    6'b100101: sel = OP_OR;
                    6'b101010: sel = OP_SLT;
                    default:   sel = OP_BAD;
                endcase
            end
            default: sel = OP_BAD;
        endcase
        return sel;
    endfunction

    logic [W-1:0] rs_data_r;
    logic [W-1:0] rt_data_r;
    logic [W-1:0] imm_r;
    logic [4:0]   rs_r;
    logic [4:0]   rt_r;
    logic [4:0]   write_reg_r;
    logic         alu_src_r;
    logic [3:0]   opsel_r;
    logic         reg_write_r;
    logic         mem_read_r;
    logic         mem_write_r;
    logic         mem_to_reg_r;
    logic         valid_r;

    logic [3:0]   opsel_s;
    logic [4:0]   write_reg_s;
    logic [W-1:0] fwd_a_s;
    logic [W-1:0] fwd_b_s;

    // Resolve the ALU operation and destination register ahead of the pipeline register
    always_comb begin
        opsel_s = alu_decode(id_alu_op, id_funct);
        if (id_reg_dst) begin
            write_reg_s = id_rd;
        end else begin
            write_reg_s = id_rt;
        end
    end

    // Pipeline register: reset and flush both load a bubble, stall holds, otherwise capture ID
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs_data_r    <= {W{1'b0}};
            rt_data_r    <= {W{1'b0}};
            imm_r        <= {W{1'b0}};
            rs_r         <= 5'd0;
            rt_r         <= 5'd0;
            write_reg_r  <= 5'd0;
            alu_src_r    <= 1'b0;
            opsel_r      <= 4'h0;
            reg_write_r  <= 1'b0;
            mem_read_r   <= 1'b0;
            mem_write_r  <= 1'b0;
            mem_to_reg_r <= 1'b0;
            valid_r      <= 1'b0;
        end else if (flush) begin
            rs_data_r    <= {W{1'b0}};
            rt_data_r    <= {W{1'b0}};
            imm_r        <= {W{1'b0}};
            rs_r         <= 5'd0;
            rt_r         <= 5'd0;
            write_reg_r  <= 5'd0;
            alu_src_r    <= 1'b0;
            opsel_r      <= 4'h0;
            reg_write_r  <= 1'b0;
            mem_read_r   <= 1'b0;
            mem_write_r  <= 1'b0;
            mem_to_reg_r <= 1'b0;
            valid_r      <= 1'b0;
        end else if (!stall) begin
            rs_data_r    <= id_rs_data;
            rt_data_r    <= id_rt_data;
            imm_r        <= id_imm;
            rs_r         <= id_rs;
            rt_r         <= id_rt;
            write_reg_r  <= write_reg_s;
            alu_src_r    <= id_alu_src;
            opsel_r      <= opsel_s;
            reg_write_r  <= id_reg_write;
            mem_read_r   <= id_mem_read;
            mem_write_r  <= id_mem_write;
            mem_to_reg_r <= id_mem_to_reg;
            valid_r      <= 1'b1;
        end else begin
            valid_r      <= valid_r;
        end
    end

    // Operand forwarding: the younger EX/MEM result wins over MEM/WB; register 0 is never forwarded
    always_comb begin
        if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == rs_r)) begin
            fwd_a_s = exmem_result;
        end else if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == rs_r)) begin
            fwd_a_s = memwb_result;
        end else begin
            fwd_a_s = rs_data_r;
        end

        if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == rt_r)) begin
            fwd_b_s = exmem_result;
        end else if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == rt_r)) begin
            fwd_b_s = memwb_result;
        end else begin
            fwd_b_s = rt_data_r;
        end
    end

    // Operand B takes the immediate for I-type instructions, else the forwarded rt value
    always_comb begin
        if (alu_src_r) begin
            alu_b = imm_r;
        end else begin
            alu_b = fwd_b_s;
        end
    end

    assign alu_a         = fwd_a_s;
    assign ex_store_data = fwd_b_s;
    assign alu_opsel     = opsel_r;
    assign ex_write_reg  = write_reg_r;
    assign ex_rs         = rs_r;
    assign ex_rt         = rt_r;
    assign ex_reg_write  = reg_write_r;
    assign ex_mem_read   = mem_read_r;
    assign ex_mem_write  = mem_write_r;
    assign ex_mem_to_reg = mem_to_reg_r;
    assign ex_valid      = valid_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage.
module tb_id_ex_stage;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         stall;
    logic         flush;
    logic [W-1:0] id_rs_data;
    logic [W-1:0] id_rt_data;
    logic [W-1:0] id_imm;
    logic [4:0]   id_rs;
    logic [4:0]   id_rt;
    logic [4:0]   id_rd;
    logic [5:0]   id_funct;
    logic [1:0]   id_alu_op;
    logic         id_alu_src;
    logic         id_reg_dst;
    logic         id_reg_write;
    logic         id_mem_read;
    logic         id_mem_write;
    logic         id_mem_to_reg;
    logic         exmem_reg_write;
    logic [4:0]   exmem_rd;
    logic [W-1:0] exmem_result;
    logic         memwb_reg_write;
    logic [4:0]   memwb_rd;
    logic [W-1:0] memwb_result;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [3:0]   alu_opsel;
    logic [W-1:0] ex_store_data;
    logic [4:0]   ex_write_reg;
    logic [4:0]   ex_rs;
    logic [4:0]   ex_rt;
    logic         ex_reg_write;
    logic         ex_mem_read;
    logic         ex_mem_write;
    logic         ex_mem_to_reg;
    logic         ex_valid;

    int pass_cnt  = 0;
    int total_cnt = 0;

    id_ex_stage #(.W(W)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_funct(id_funct),
        .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opsel(alu_opsel), .ex_store_data(ex_store_data),
        .ex_write_reg(ex_write_reg), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_valid(ex_valid)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Put every ID and forwarding input into a neutral state
    task automatic clear_inputs();
        stall = 1'b0; flush = 1'b0;
        id_rs_data = 32'd0; id_rt_data = 32'd0; id_imm = 32'd0;
        id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd0; id_funct = 6'd0;
        id_alu_op = 2'b00; id_alu_src = 1'b0; id_reg_dst = 1'b0;
        id_reg_write = 1'b0; id_mem_read = 1'b0; id_mem_write = 1'b0; id_mem_to_reg = 1'b0;
        exmem_reg_write = 1'b0; exmem_rd = 5'd0; exmem_result = 32'd0;
        memwb_reg_write = 1'b0; memwb_rd = 5'd0; memwb_result = 32'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        step();
        step();
        total_cnt++;
        if ({alu_a, alu_b, ex_store_data} !== 96'd0) $display("FAIL reset_data a=%h b=%h sd=%h expected 0", alu_a, alu_b, ex_store_data);
        else pass_cnt++;
        total_cnt++;
        if ({alu_opsel, ex_write_reg, ex_rs, ex_rt, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_valid} !== 24'd0)
            $display("FAIL reset_ctrl opsel=%h wr=%0d valid=%b rw=%b expected 0", alu_opsel, ex_write_reg, ex_valid, ex_reg_write);
        else pass_cnt++;
    endtask

    task automatic test_add();
        #2 rst = 1'b0;
        id_alu_op = 2'b10; id_funct = 6'b100000;
        id_rs_data = 32'd5; id_rt_data = 32'd7; id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd3;
        id_reg_dst = 1'b1; id_reg_write = 1'b1;
        step();
        total_cnt++;
        if (alu_opsel !== 4'h2 || alu_a !== 32'd5 || alu_b !== 32'd7)
            $display("FAIL add_ops opsel=%h a=%0d b=%0d expected 2/5/7", alu_opsel, alu_a, alu_b);
        else pass_cnt++;
        total_cnt++;
        if (ex_write_reg !== 5'd3 || ex_valid !== 1'b1 || ex_reg_write !== 1'b1)
            $display("FAIL add_ctrl wr=%0d valid=%b rw=%b expected 3/1/1", ex_write_reg, ex_valid, ex_reg_write);
        else pass_cnt++;
    endtask

    task automatic test_forward();
        clear_inputs();
        id_rs = 5'd4; id_rs_data = 32'h99; id_rt = 5'd5; id_rt_data = 32'h66; id_alu_op = 2'b10; id_funct = 6'b100000;
        step();
        exmem_reg_write = 1'b1; exmem_rd = 5'd4; exmem_result = 32'h11;
        memwb_reg_write = 1'b1; memwb_rd = 5'd4; memwb_result = 32'h22;
        #1;
        total_cnt++;
        if (alu_a !== 32'h11) $display("FAIL fwd_exmem_prio alu_a=%h expected 11", alu_a);
        else pass_cnt++;
        exmem_reg_write = 1'b0;
        #1;
        total_cnt++;
        if (alu_a !== 32'h22) $display("FAIL fwd_memwb alu_a=%h expected 22", alu_a);
        else pass_cnt++;
        memwb_rd = 5'd5;
        #1;
        total_cnt++;
        if (alu_a !== 32'h99 || alu_b !== 32'h22) $display("FAIL fwd_b_memwb a=%h b=%h expected 99/22", alu_a, alu_b);
        else pass_cnt++;
    endtask

    task automatic test_reg0();
        clear_inputs();
        id_rt = 5'd0; id_rt_data = 32'd0; id_rs = 5'd0;
        step();
        exmem_reg_write = 1'b1; exmem_rd = 5'd0; exmem_result = 32'hDEAD;
        memwb_reg_write = 1'b1; memwb_rd = 5'd0; memwb_result = 32'hBEEF;
        #1;
        total_cnt++;
        if (alu_b !== 32'd0 || ex_store_data !== 32'd0 || alu_a !== 32'd0)
            $display("FAIL reg0_no_fwd a=%h b=%h sd=%h expected 0", alu_a, alu_b, ex_store_data);
        else pass_cnt++;
    endtask

    task automatic test_lw_sw();
        clear_inputs();
        id_alu_op = 2'b00; id_alu_src = 1'b1; id_imm = 32'hFFFFFFFC; id_reg_dst = 1'b0;
        id_rt = 5'd8; id_rd = 5'd17; id_rs = 5'd2; id_mem_read = 1'b1; id_reg_write = 1'b1; id_mem_to_reg = 1'b1;
        step();
        total_cnt++;
        if (alu_opsel !== 4'h2 || alu_b !== 32'hFFFFFFFC || ex_write_reg !== 5'd8 || ex_mem_read !== 1'b1 || ex_mem_to_reg !== 1'b1)
            $display("FAIL lw opsel=%h b=%h wr=%0d mr=%b m2r=%b expected 2/fffffffc/8/1/1", alu_opsel, alu_b, ex_write_reg, ex_mem_read, ex_mem_to_reg);
        else pass_cnt++;
        clear_inputs();
        id_alu_op = 2'b00; id_alu_src = 1'b1; id_imm = 32'd16; id_rt = 5'd9; id_rt_data = 32'h1; id_mem_write = 1'b1;
        step();
        exmem_reg_write = 1'b1; exmem_rd = 5'd9; exmem_result = 32'h55;
        #1;
        total_cnt++;
        if (ex_store_data !== 32'h55 || alu_b !== 32'd16 || ex_mem_write !== 1'b1 || ex_reg_write !== 1'b0)
            $display("FAIL sw_fwd sd=%h b=%h mw=%b rw=%b expected 55/10/1/0", ex_store_data, alu_b, ex_mem_write, ex_reg_write);
        else pass_cnt++;
    endtask

    task automatic test_stall_flush();
        clear_inputs();
        id_alu_op = 2'b10; id_funct = 6'b101010; id_rs = 5'd6; id_rs_data = 32'hA;
        id_rt = 5'd7; id_rd = 5'd10; id_reg_dst = 1'b1; id_reg_write = 1'b1;
        step();
        total_cnt++;
        if (alu_opsel !== 4'h7) $display("FAIL slt_load opsel=%h expected 7", alu_opsel);
        else pass_cnt++;
        stall = 1'b1;
        id_funct = 6'b100000; id_rs_data = 32'hB; id_rs = 5'd11; id_rd = 5'd12; id_reg_write = 1'b0; id_mem_read = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            total_cnt++;
            if (alu_opsel !== 4'h7 || alu_a !== 32'hA || ex_write_reg !== 5'd10 || ex_rs !== 5'd6 || ex_reg_write !== 1'b1 || ex_mem_read !== 1'b0 || ex_valid !== 1'b1)
                $display("FAIL stall_hold cycle=%0d opsel=%h a=%h wr=%0d rs=%0d rw=%b mr=%b expected 7/a/10/6/1/0", i, alu_opsel, alu_a, ex_write_reg, ex_rs, ex_reg_write, ex_mem_read);
            else pass_cnt++;
        end
        flush = 1'b1;
        step();
        total_cnt++;
        if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0 || ex_mem_write !== 1'b0 || ex_mem_to_reg !== 1'b0 ||
            ex_write_reg !== 5'd0 || ex_rs !== 5'd0 || ex_rt !== 5'd0 || alu_opsel !== 4'h0 || alu_a !== 32'd0)
            $display("FAIL flush_bubble valid=%b rw=%b mr=%b wr=%0d rs=%0d opsel=%h a=%h expected all 0", ex_valid, ex_reg_write, ex_mem_read, ex_write_reg, ex_rs, alu_opsel, alu_a);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        clear_inputs();
        id_alu_op = 2'b10; id_funct = 6'b100010; id_rs = 5'd3; id_rs_data = 32'd3; id_rt = 5'd4; id_rt_data = 32'd4;
        id_reg_write = 1'b1;
        step();
        total_cnt++;
        if (alu_opsel !== 4'h6 || alu_a !== 32'd3 || alu_b !== 32'd4) $display("FAIL sub_load opsel=%h a=%0d b=%0d expected 6/3/4", alu_opsel, alu_a, alu_b);
        else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        total_cnt++;
        if (alu_opsel !== 4'h0 || ex_valid !== 1'b0 || alu_a !== 32'd0 || alu_b !== 32'd0 || ex_reg_write !== 1'b0)
            $display("FAIL async_reset opsel=%h valid=%b a=%h b=%h rw=%b expected 0", alu_opsel, ex_valid, alu_a, alu_b, ex_reg_write);
        else pass_cnt++;
        #1 rst = 1'b0;
        id_funct = 6'b000111;
        step();
        total_cnt++;
        if (alu_opsel !== 4'hF || ex_valid !== 1'b1) $display("FAIL undef_funct opsel=%h valid=%b expected f/1", alu_opsel, ex_valid);
        else pass_cnt++;
        id_alu_op = 2'b11;
        step();
        total_cnt++;
        if (alu_opsel !== 4'h1) $display("FAIL ori_opsel opsel=%h expected 1", alu_opsel);
        else pass_cnt++;
        id_alu_op = 2'b10; id_funct = 6'b100100;
        step();
        total_cnt++;
        if (alu_opsel !== 4'h0 || ex_valid !== 1'b1) $display("FAIL and_opsel opsel=%h valid=%b expected 0/1", alu_opsel, ex_valid);
        else pass_cnt++;
        id_alu_op = 2'b01;
        step();
        total_cnt++;
        if (alu_opsel !== 4'h6) $display("FAIL beq_opsel opsel=%h expected 6", alu_opsel);
        else pass_cnt++;
    endtask

    // Run the scenarios in order and report
    initial begin
        test_reset();
        test_add();
        test_forward();
        test_reg0();
        test_lw_sw();
        test_stall_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
